fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage for the 16-bit single-issue core. Holds the PC, issues one read per instruction to instruction memory, buffers the returned word and presents it to the decode/control block together with its PC and PC+2. Consumes the decoder's halt and the execute stage's branch/jump redirect, and stops fetching permanently after a HALT is accepted.

## Interface

- RESET_PC, 16'h0000, PC loaded on reset.
- NOP_WORD, 16'h0800, instruction word presented while no valid instruction is held (opcode 00001).

- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_rd  out  1  read request; held high until imem_done.
- imem_addr  out  16  read address, equal to pc while imem_rd is high.
- imem_data  in  16  read data; valid only when imem_done is high.
- imem_done  in  1  one-cycle completion pulse; may arrive in the same cycle imem_rd first rises.
- instr  out  16  buffered instruction.
- opCode  out  5  instr[15:11].
- func  out  2  instr[1:0].
- instr_pc  out  16  address instr was fetched from.
- pc_plus2  out  16  instr_pc + 2, mod 2^16.
- instr_valid  out  1  instr is valid and offered to decode.
- dec_ready  in  1  decode accepts instr this cycle (handshake completes on instr_valid && dec_ready).
- halt  in  1  decoder flags the offered instruction as HALT; sampled only at handshake.
- redirect  in  1  load redirect_pc as next fetch address.
- redirect_pc  in  16  redirect target; bit 0 ignored (forced 0).
- halted  out  1  fetch stopped after HALT.

## Operation

- States: RESET, FETCH, VALID, HALTED. Outputs imem_rd, instr_valid and halted decode from state only.
- RESET: entered asynchronously while rst_n low; no request. Next cycle after rst_n high: FETCH.
- FETCH: imem_rd=1, imem_addr=pc. On imem_done with kill=0: instr<=imem_data, instr_pc<=pc, pc<=pc+2, go VALID. On imem_done with kill=1: discard data, clear kill, stay FETCH (new request next cycle at the already-updated pc).
- VALID: instr_valid=1, instr/instr_pc stable until handshake or redirect. On handshake:
  - halt=1: go HALTED (halt has priority over redirect).
  - otherwise: go FETCH; if redirect=1, pc<=redirect_pc.
- Redirect without handshake in VALID: drop buffered instruction, pc<=redirect_pc, go FETCH.
- Redirect in FETCH: pc<=redirect_pc. If imem_done is not high the same cycle, set kill so the in-flight response is discarded. If imem_done is high the same cycle, discard the data and stay in FETCH; kill stays 0.
- HALTED: imem_rd=0, instr_valid=0, halted=1; all inputs ignored until reset.
- When instr_valid=0, instr reads NOP_WORD.
- pc arithmetic is 16-bit unsigned and wraps: 16'hFFFE + 2 = 16'h0000.

## Timing

- Reset values: state RESET, pc=RESET_PC, instr=NOP_WORD, instr_pc=RESET_PC, pc_plus2=RESET_PC+2, kill=0, imem_rd=0, instr_valid=0, halted=0.
- First request: imem_rd rises in the first cycle after rst_n deasserts.
- Zero-wait memory (imem_done in the same cycle as imem_rd): instr_valid rises the next cycle. Peak throughput is one instruction per 2 cycles.
- Each memory wait cycle adds one cycle. Each dec_ready-low cycle in VALID adds one cycle.
- Reset asserted mid-request: the request drops immediately. Memory must tolerate the abandoned read.
- imem_done outside FETCH is ignored.

## Test plan

- Reset release, zero-wait memory returning 16'h4123 at address 0 -> imem_rd high in cycle 1; instr_valid in cycle 2 with instr=16'h4123, opCode=5'b01000, instr_pc=0, pc_plus2=2; next imem_addr=2.
- Memory with 3 wait cycles, dec_ready low for 2 cycles -> instr and instr_pc held stable; no second request until the handshake; handshake-to-next-instr_valid is 2 cycles.
- Redirect to 16'h0041 in FETCH while a request is outstanding, response 16'hDEAD arrives 2 cycles later -> 16'hDEAD never shown; next imem_addr=16'h0040.
- Handshake with halt=1 and redirect=1 in the same cycle -> HALTED, halted=1, imem_rd stays 0 for 20 further cycles.
- Redirect to 16'hFFFE then sequential fetch -> second address is 16'h0000; pc_plus2 of the first instruction is 16'h0000.
- rst_n low during a FETCH wait cycle -> all outputs at reset values immediately; refetch from RESET_PC after release.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch stage bundle: instruction-memory read port plus the decode-side
// instruction offer, redirect and halt signalling.
interface fetch_if;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_done;
  logic [15:0] instr;
  logic [4:0]  opCode;
  logic [1:0]  func;
  logic [15:0] instr_pc;
  logic [15:0] pc_plus2;
  logic        instr_valid;
  logic        dec_ready;
  logic        halt;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halted;

  modport master (
    output imem_rd,
    output imem_addr,
    input  imem_data,
    input  imem_done,
    output instr,
    output opCode,
    output func,
    output instr_pc,
    output pc_plus2,
    output instr_valid,
    input  dec_ready,
    input  halt,
    input  redirect,
    input  redirect_pc,
    output halted
  );

  modport slave (
    input  imem_rd,
    input  imem_addr,
    output imem_data,
    output imem_done,
    input  instr,
    input  opCode,
    input  func,
    input  instr_pc,
    input  pc_plus2,
    input  instr_valid,
    output dec_ready,
    output halt,
    output redirect,
    output redirect_pc,
    input  halted
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one imem read per instruction, single-entry
// buffer offered to decode, redirect handling and permanent halt.
module fetch_stage (
  input  logic    clk,
  input  logic    rst_n,
  fetch_if.master f
);
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] NOP_WORD = 16'h0800;

  localparam logic [1:0] S_RESET  = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_VALID  = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  logic [1:0]  state;
  logic [15:0] pc;
  logic [15:0] instr_q;
  logic [15:0] ipc;
  logic        kill;
  logic        hs;
  logic [15:0] target;

  assign hs     = (state == S_VALID) && f.dec_ready;
  assign target = f.redirect_pc & 16'hFFFE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_RESET;
      pc      <= RESET_PC;
      instr_q <= NOP_WORD;
      ipc     <= RESET_PC;
      kill    <= 1'b0;
    end else begin
      unique case (state)
        S_RESET: state <= S_FETCH;
        S_FETCH: begin
          if (f.redirect) begin
            pc   <= target;
            // a response landing this cycle belongs to the old path
            kill <= ~f.imem_done;
          end else if (f.imem_done) begin
            if (kill) begin
              kill <= 1'b0;
            end else begin
              instr_q <= f.imem_data;
              ipc     <= pc;
              pc      <= pc + 16'd2;
              state   <= S_VALID;
            end
          end
        end
        S_VALID: begin
          if (hs && f.halt) begin
            state <= S_HALTED;
          end else if (hs || f.redirect) begin
            state <= S_FETCH;
            if (f.redirect) pc <= target;
          end
        end
        S_HALTED: state <= S_HALTED;
        default:  state <= S_RESET;
      endcase
    end
  end

  assign f.imem_rd     = (state == S_FETCH);
  assign f.imem_addr   = pc;
  assign f.instr_valid = (state == S_VALID);
  assign f.halted      = (state == S_HALTED);
  assign f.instr       = f.instr_valid ? instr_q : NOP_WORD;
  assign f.opCode      = f.instr[15:11];
  assign f.func        = f.instr[1:0];
  assign f.instr_pc    = ipc;
  assign f.pc_plus2    = ipc + 16'd2;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, wait states, backpressure,
// redirect/kill, wraparound, halt and mid-request reset.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  fetch_if f();

  fetch_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .f     (f)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    check({tag, ".rd"}, 32'(f.imem_rd), 32'd0);
    check({tag, ".vld"}, 32'(f.instr_valid), 32'd0);
    check({tag, ".hlt"}, 32'(f.halted), 32'd0);
    check({tag, ".instr"}, 32'(f.instr), 32'h0800);
    check({tag, ".ipc"}, 32'(f.instr_pc), 32'h0000);
    check({tag, ".pc2"}, 32'(f.pc_plus2), 32'h0002);
  endtask

  initial begin
    f.imem_data   = 16'h0000;
    f.imem_done   = 1'b0;
    f.dec_ready   = 1'b0;
    f.halt        = 1'b0;
    f.redirect    = 1'b0;
    f.redirect_pc = 16'h0000;

    tick();
    tick();
    chk_reset("rst");

    rst_n = 1'b1;
    tick();
    check("t1.rd", 32'(f.imem_rd), 32'd1);
    check("t1.addr", 32'(f.imem_addr), 32'h0000);
    f.imem_data = 16'h4123;
    f.imem_done = 1'b1;
    tick();
    f.imem_done = 1'b0;
    check("t1.vld", 32'(f.instr_valid), 32'd1);
    check("t1.instr", 32'(f.instr), 32'h4123);
    check("t1.op", 32'(f.opCode), 32'h08);
    check("t1.func", 32'(f.func), 32'h3);
    check("t1.ipc", 32'(f.instr_pc), 32'h0000);
    check("t1.pc2", 32'(f.pc_plus2), 32'h0002);
    check("t1.rd0", 32'(f.imem_rd), 32'd0);
    f.dec_ready = 1'b1;
    tick();
    check("t1.addr2", 32'(f.imem_addr), 32'h0002);
    check("t1.rd2", 32'(f.imem_rd), 32'd1);

    f.dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2.wait_rd", 32'(f.imem_rd), 32'd1);
      check("t2.wait_vld", 32'(f.instr_valid), 32'd0);
    end
    f.imem_data = 16'h2A5C;
    f.imem_done = 1'b1;
    tick();
    f.imem_done = 1'b0;
    f.imem_data = 16'hFFFF;
    check("t2.instr", 32'(f.instr), 32'h2A5C);
    check("t2.ipc", 32'(f.instr_pc), 32'h0002);
    tick();
    check("t2.hold_instr", 32'(f.instr), 32'h2A5C);
    check("t2.hold_ipc", 32'(f.instr_pc), 32'h0002);
    check("t2.hold_rd", 32'(f.imem_rd), 32'd0);
    f.dec_ready = 1'b1;
    tick();
    check("t2.hs_rd", 32'(f.imem_rd), 32'd1);
    check("t2.hs_addr", 32'(f.imem_addr), 32'h0004);
    f.imem_data = 16'h1111;
    f.imem_done = 1'b1;
    tick();
    f.imem_done = 1'b0;
    check("t2.vld2", 32'(f.instr_valid), 32'd1);
    check("t2.ipc2", 32'(f.instr_pc), 32'h0004);
    tick();
    check("t3.addr6", 32'(f.imem_addr), 32'h0006);

    f.redirect    = 1'b1;
    f.redirect_pc = 16'h0041;
    tick();
    f.redirect = 1'b0;
    check("t3.raddr", 32'(f.imem_addr), 32'h0040);
    check("t3.rd", 32'(f.imem_rd), 32'd1);
    tick();
    f.imem_data = 16'hDEAD;
    f.imem_done = 1'b1;
    tick();
    f.imem_done = 1'b0;
    check("t3.kill_vld", 32'(f.instr_valid), 32'd0);
    check("t3.kill_instr", 32'(f.instr), 32'h0800);
    check("t3.re_addr", 32'(f.imem_addr), 32'h0040);
    check("t3.re_rd", 32'(f.imem_rd), 32'd1);
    f.imem_data = 16'h3333;
    f.imem_done = 1'b1;
    tick();
    f.imem_done = 1'b0;
    check("t3.instr", 32'(f.instr), 32'h3333);
    check("t3.ipc", 32'(f.instr_pc), 32'h0040);

    f.dec_ready   = 1'b0;
    f.redirect    = 1'b1;
    f.redirect_pc = 16'hFFFF;
    tick();
    f.redirect = 1'b0;
    check("t5.drop_vld", 32'(f.instr_valid), 32'd0);
    check("t5.addr", 32'(f.imem_addr), 32'hFFFE);
    f.imem_data = 16'h1234;
    f.imem_done = 1'b1;
    tick();
    f.imem_done = 1'b0;
    check("t5.ipc", 32'(f.instr_pc), 32'hFFFE);
    check("t5.pc2", 32'(f.pc_plus2), 32'h0000);
    check("t5.instr", 32'(f.instr), 32'h1234);
    f.dec_ready = 1'b1;
    tick();
    check("t5.wrap", 32'(f.imem_addr), 32'h0000);

    f.imem_data   = 16'hBEEF;
    f.imem_done   = 1'b1;
    f.redirect    = 1'b1;
    f.redirect_pc = 16'h0100;
    tick();
    f.imem_done = 1'b0;
    f.redirect  = 1'b0;
    check("t7.vld", 32'(f.instr_valid), 32'd0);
    check("t7.addr", 32'(f.imem_addr), 32'h0100);
    tick();
    f.imem_data = 16'h5555;
    f.imem_done = 1'b1;
    tick();
    f.imem_done = 1'b0;
    check("t7.instr", 32'(f.instr), 32'h5555);
    check("t7.ipc", 32'(f.instr_pc), 32'h0100);

    f.halt        = 1'b1;
    f.redirect    = 1'b1;
    f.redirect_pc = 16'h0200;
    tick();
    check("t4.halted", 32'(f.halted), 32'd1);
    check("t4.vld", 32'(f.instr_valid), 32'd0);
    check("t4.instr", 32'(f.instr), 32'h0800);
    for (int i = 0; i < 20; i++) begin
      f.imem_done = 1'(i % 2);
      f.redirect  = 1'(i % 3 == 0);
      f.halt      = 1'b0;
      tick();
      check("t4.rd", 32'(f.imem_rd), 32'd0);
      check("t4.hlt", 32'(f.halted), 32'd1);
    end
    f.imem_done = 1'b0;
    f.redirect  = 1'b0;
    f.dec_ready = 1'b0;

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("t6.addr", 32'(f.imem_addr), 32'h0000);
    check("t6.rd", 32'(f.imem_rd), 32'd1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("t6.async");
    tick();
    rst_n = 1'b1;
    tick();
    check("t6.re_rd", 32'(f.imem_rd), 32'd1);
    check("t6.re_addr", 32'(f.imem_addr), 32'h0000);
    f.imem_data = 16'h7777;
    f.imem_done = 1'b1;
    tick();
    f.imem_done = 1'b0;
    check("t6.vld", 32'(f.instr_valid), 32'd1);
    check("t6.instr", 32'(f.instr), 32'h7777);
    check("t6.ipc", 32'(f.instr_pc), 32'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
